// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants, register word type and byte-merge helper
// for the reg_file_sb register file.
package reg_file_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_DEPTH = 8;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int unsigned MAX_WIDTH = 256;
    localparam int unsigned MAX_BYTES = MAX_WIDTH / 8;

    typedef logic [DEF_WIDTH-1:0] word_t;
    typedef logic [MAX_WIDTH-1:0] merge_word_t;
    typedef logic [MAX_BYTES-1:0] merge_be_t;

    // Byte i of the result comes from new_w when be[i] is set, else from old_w.
    function automatic merge_word_t byte_merge(merge_word_t old_w,
                                               merge_word_t new_w,
                                               merge_be_t   be);
        merge_word_t res;
        res = old_w;
        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: one pending-write bit per register. Issue sets,
// writeback clears, issue wins when both hit the same index.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned AW       = $clog2(DEPTH),
    parameter int unsigned ZERO_REG = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_set_en,
    input  logic [AW-1:0] i_set_idx,
    input  logic          i_clr_en,
    input  logic [AW-1:0] i_clr_idx,
    input  logic [AW-1:0] i_rd_idx1,
    input  logic [AW-1:0] i_rd_idx2,
    output logic          o_busy1,
    output logic          o_busy2
);

    logic [DEPTH-1:0] r_busy;
    logic             w_set_ok;

    // Issues to a hardwired-zero register are dropped.
    always_comb begin
        w_set_ok = i_set_en && !((ZERO_REG != 0) && (i_set_idx == '0));
    end

    // Busy flops: reset clears all; set has priority over clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (w_set_ok && (i_set_idx == AW'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (i_clr_en && (i_clr_idx == AW'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    // Read-out muxes for the two read ports.
    always_comb begin
        o_busy1 = r_busy[i_rd_idx1];
        o_busy2 = r_busy[i_rd_idx2];
    end

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: DEPTH x WIDTH register file, 2 async read / 1 byte-enabled
// write port, optional hardwired-zero register 0, pending-write scoreboard.
// Optional macro REGFILE_WRITE_BYPASS_EN: forwards the in-flight write to
// read ports addressing the same register in the same cycle.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned AW       = $clog2(DEPTH),
    parameter int unsigned ZERO_REG = 1
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               RegWrite,
    input  logic [AW-1:0]      WriteRegNo,
    input  logic [WIDTH-1:0]   WriteData,
    input  logic [WIDTH/8-1:0] WriteByteEn,
    input  logic               IssueValid,
    input  logic [AW-1:0]      IssueRegNo,
    input  logic [AW-1:0]      ReadReg1,
    input  logic [AW-1:0]      ReadReg2,
    output logic [WIDTH-1:0]   ReadData1,
    output logic [WIDTH-1:0]   ReadData2,
    output logic               Busy1,
    output logic               Busy2
);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [WIDTH-1:0] w_wr_merged;
    logic             w_wr_en;
    logic             w_sb_busy1;
    logic             w_sb_busy2;

    // Merged write word and write qualification (register 0 may be hardwired).
    always_comb begin
        w_wr_merged = WIDTH'(byte_merge(MAX_WIDTH'(r_regs[WriteRegNo]),
                                        MAX_WIDTH'(WriteData),
                                        MAX_BYTES'(WriteByteEn)));
        w_wr_en     = RegWrite && !((ZERO_REG != 0) && (WriteRegNo == '0));
    end

    // Data array: reset clears everything, otherwise byte-enabled writeback.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[WriteRegNo] <= w_wr_merged;
        end
    end

    reg_file_scoreboard #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .i_clk     (Clock),
        .i_rst     (Reset),
        .i_set_en  (IssueValid),
        .i_set_idx (IssueRegNo),
        .i_clr_en  (RegWrite),
        .i_clr_idx (WriteRegNo),
        .i_rd_idx1 (ReadReg1),
        .i_rd_idx2 (ReadReg2),
        .o_busy1   (w_sb_busy1),
        .o_busy2   (w_sb_busy2)
    );

    // Read port 1: stored value, optional same-cycle forward, zero override.
    always_comb begin
        ReadData1 = r_regs[ReadReg1];
        Busy1     = w_sb_busy1;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (w_wr_en && (ReadReg1 == WriteRegNo)) begin
            ReadData1 = w_wr_merged;
            if (!(IssueValid && (IssueRegNo == ReadReg1))) begin
                Busy1 = 1'b0;
            end
        end
`endif
        if ((ZERO_REG != 0) && (ReadReg1 == '0)) begin
            ReadData1 = '0;
            Busy1     = 1'b0;
        end
    end

    // Read port 2: same structure as port 1.
    always_comb begin
        ReadData2 = r_regs[ReadReg2];
        Busy2     = w_sb_busy2;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (w_wr_en && (ReadReg2 == WriteRegNo)) begin
            ReadData2 = w_wr_merged;
            if (!(IssueValid && (IssueRegNo == ReadReg2))) begin
                Busy2 = 1'b0;
            end
        end
`endif
        if ((ZERO_REG != 0) && (ReadReg2 == '0)) begin
            ReadData2 = '0;
            Busy2     = 1'b0;
        end
    end

endmodule
